instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
//  Packs decoded instruction fields (opcode, rs, rt, shAmt, imm, jAddr) into 32-bit KGP_RISC words.
//  Streams the packed words into instruction memory through a registered write port.
//  It is the inverse of the instruction decoder: a word it writes decodes back to the same fields.
//  It sits between the loader/test host and the instruction memory write port.
// PARAMETERS
//  ADDR_W     5   width of the instruction-memory word address
//  DEPTH      32  max words per load session (must be <= 2**ADDR_W)
//  BASE_ADDR  0   first word address written after start
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   pulse: open a load session (honoured only in IDLE)
//  abort       in   1   pulse: end session immediately, back to IDLE
//  in_valid    in   1   field bundle valid
//  in_ready    out  1   encoder can accept a bundle this cycle
//  in_last     in   1   bundle is the final word of the session
//  fmt         in   2   0=R/shift, 1=I, 2=J, 3=illegal
//  opcode      in   6   opcode field
//  rsAddr      in   5   rs field
//  rtAddr      in   5   rt field
//  shAmt       in   5   shift amount
//  imm         in   16  immediate
//  jAddr       in   26  jump target
//  imem_we     out  1   instruction-memory write strobe
//  imem_addr   out  ADDR_W  write word address
//  imem_wdata  out  32  packed instruction
//  wr_count    out  ADDR_W+1  words written this session
//  done        out  1   session complete, held until next start
//  err         out  1   sticky: illegal fmt seen this session
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; in_ready=0; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; wr_count=0; done=0; err=0.
//  Packing:
//  - R: {opcode,rsAddr,rtAddr,5'b0,shAmt,6'b0}, so shAmt occupies [10:6].
//  - I: {opcode,rsAddr,rtAddr,imm}.
//  - J: {opcode,jAddr}.
//  - Unused fields are ignored.
//  States:
//  - IDLE: in_ready=0. start -> LOAD; in the same edge clear wr_count, done and err and set the address pointer to BASE_ADDR.
//  - LOAD: in_ready = (wr_count < DEPTH).
//    - Accept = in_valid & in_ready.
//    - An accepted legal beat registers the packed word and raises imem_we for exactly the next cycle, with imem_addr = pointer.
//    - The pointer and wr_count increment at that same edge. Latency from accept to the write strobe is 1 cycle.
//    - Back-to-back accepts give a write every cycle.
//    - Accept with in_last, or the accept that brings wr_count to DEPTH -> DONE.
//  - DONE: in_ready=0; done=1. start -> LOAD (new session, as from IDLE).
//  - Any state + abort -> IDLE; done=0; err keeps its value.
//  Illegal fmt=3: the beat is consumed, nothing is written, the pointer does not advance, and err is set.
//  - If in_last is set on the illegal beat, the state still goes to DONE.
//  Boundaries:
//  - A write already registered when abort or DONE is taken still completes the following cycle.
//  - Address wrap: the pointer wraps modulo 2**ADDR_W when BASE_ADDR+DEPTH exceeds the range.
//  - start in LOAD is ignored.
//  - abort and start in the same cycle: abort wins.
//  - Reset mid-session drops any pending write (imem_we=0 from the reset edge).
// TESTING
//  1. Reset, start, then R op=000011 rs=7 rt=8 shAmt=2 -> next cycle imem_we=1, addr=0, wdata=32'h0CE80080.
//  2. I op=000101 rs=7 rt=9 imm=1, then J op=110110 jAddr=3 with in_last, back-to-back
//     -> writes 32'h14E90001 @0 and 32'hD8000003 @1 on consecutive cycles; done=1, wr_count=2.
//  3. DEPTH=4: hold in_valid for 6 beats -> exactly 4 writes @0..3; in_ready=0 after the 4th accept; done=1.
//  4. fmt=3 between two legal beats -> err=1; legal words land @0 and @1 with no gap in addresses.
//  5. abort one cycle after an accept -> the pending write completes, then state is IDLE with in_ready=0; a new start restarts at BASE_ADDR.
//  6. Assert rst mid-LOAD with a write pending -> imem_we=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Packs decoded KGP_RISC instruction fields into 32-bit words and streams
//   them into instruction memory through a registered write port. A word
//   written here decodes back to the same fields.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start, abort          session control pulses (abort has priority)
//   in_valid/in_ready     field-bundle handshake; in_last marks final bundle
//   fmt                   0=R/shift, 1=I, 2=J, 3=illegal
//   opcode..jAddr         instruction fields
//   imem_we/addr/wdata    registered instruction-memory write port
//   wr_count              words written this session
//   done                  session complete, held until next start
//   err                   sticky illegal-fmt flag, cleared by start
module instruction_encoder #(
   parameter int ADDR_W    = 5,
   parameter int DEPTH     = 32,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        fmt,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rsAddr,
   input  logic [4:0]        rtAddr,
   input  logic [4:0]        shAmt,
   input  logic [15:0]       imm,
   input  logic [25:0]       jAddr,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   wr_count,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] ptr_reg;
   logic              accept;
   logic              legal;
   logic              start_take;
   logic [31:0]       packed_word;

   assign legal  = (fmt != 2'd3);
   assign accept = in_valid && in_ready;
   // start is only honoured outside LOAD, and abort overrides it.
   assign start_take = start && !abort && (state_reg != LOAD);
   assign done = (state_reg == DONE);

   always_comb begin
      packed_word = 32'd0;
      case (fmt)
         2'd0:    packed_word = {opcode, rsAddr, rtAddr, 5'b0, shAmt, 6'b0};
         2'd1:    packed_word = {opcode, rsAddr, rtAddr, imm};
         2'd2:    packed_word = {opcode, jAddr};
         default: packed_word = 32'd0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
            in_ready = (wr_count < DEPTH_W);
            // Illegal beats never bump wr_count, so only a legal beat can
            // fill the session; in_last ends it either way.
            if (accept && (in_last || (legal && (wr_count + 1'b1) == DEPTH_W)))
               state_next = DONE;
         end
         DONE: begin
            if (start) state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
      if (abort) state_next = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         ptr_reg    <= BASE;
         imem_we    <= 1'b0;
         imem_addr  <= BASE;
         imem_wdata <= 32'd0;
         wr_count   <= '0;
         err        <= 1'b0;
      end else begin
         state_reg <= state_next;
         // The strobe lasts one cycle; a write registered here completes
         // next cycle even if the session ends at this edge.
         imem_we   <= accept && legal;
         if (start_take) begin
            ptr_reg  <= BASE;
            wr_count <= '0;
            err      <= 1'b0;
         end else if (accept) begin
            if (legal) begin
               imem_addr  <= ptr_reg;
               imem_wdata <= packed_word;
               ptr_reg    <= ptr_reg + 1'b1;   // wraps modulo 2**ADDR_W
               wr_count   <= wr_count + 1'b1;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0, abort = 1'b0;
   logic              in_valid = 1'b0, in_last = 1'b0;
   logic              in_ready;
   logic [1:0]        fmt = 2'd0;
   logic [5:0]        opcode = '0;
   logic [4:0]        rsAddr = '0, rtAddr = '0, shAmt = '0;
   logic [15:0]       imm = '0;
   logic [25:0]       jAddr = '0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   wr_count;
   logic              done, err;

   instruction_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .fmt(fmt), .opcode(opcode), .rsAddr(rsAddr), .rtAddr(rtAddr),
      .shAmt(shAmt), .imm(imm), .jAddr(jAddr),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .wr_count(wr_count), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs, rt, sh;
      logic [15:0] imm;
      logic [25:0] j;
      logic        last;
      logic [31:0] word;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   vec_t vecs [8];
   wr_t  q [$];
   int   n_pass = 0, n_total = 0;
   int   cyc = 0, prev_wr_cyc = -10, last_wr_cyc = -10;
   logic [ADDR_W-1:0] exp_ptr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: each write strobe pops the oldest expected write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         prev_wr_cyc = last_wr_cyc;
         last_wr_cyc = cyc;
         if (q.size() == 0) begin
            chk("write_expected", {31'd0, imem_we}, 32'd0);
         end else begin
            wr_t e;
            e = q.pop_front();
            chk("wr_addr", {27'd0, imem_addr}, {27'd0, e.addr});
            chk("wr_data", imem_wdata, e.data);
            $display("write @%0d data=%h (expected @%0d %h)", imem_addr, imem_wdata, e.addr, e.data);
         end
      end
   end

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      exp_ptr = '0;
      #1 start = 1'b0;
      chk("start_in_ready", {31'd0, in_ready}, 32'd1);
      chk("start_wr_count", {26'd0, wr_count}, 32'd0);
      chk("start_done", {31'd0, done}, 32'd0);
      chk("start_err", {31'd0, err}, 32'd0);
   endtask

   // Drive one beat; if it was accepted and legal, queue its expected write.
   task automatic send(input vec_t v);
      logic acc;
      @(negedge clk);
      in_valid = 1'b1; fmt = v.fmt; opcode = v.op; rsAddr = v.rs; rtAddr = v.rt;
      shAmt = v.sh; imm = v.imm; jAddr = v.j; in_last = v.last;
      #1 acc = in_ready;
      @(posedge clk);
      if (acc && v.fmt != 2'd3) begin
         wr_t e;
         e.addr = exp_ptr;
         e.data = v.word;
         q.push_back(e);
         exp_ptr = exp_ptr + 1'b1;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drained(input string name);
      chk(name, q.size(), 0);
   endtask

   initial begin
      vecs[0] = '{2'd0, 6'h03, 5'd7,  5'd8,  5'd2,  16'h0000, 26'h0,       1'b1, 32'h0CE80080};
      vecs[1] = '{2'd1, 6'h05, 5'd7,  5'd9,  5'd0,  16'h0001, 26'h0,       1'b0, 32'h14E90001};
      vecs[2] = '{2'd2, 6'h36, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3,       1'b1, 32'hD8000003};
      vecs[3] = '{2'd0, 6'h00, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h03FF07C0};
      vecs[4] = '{2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h00000000};
      vecs[5] = '{2'd1, 6'h23, 5'd1,  5'd2,  5'd31, 16'hBEEF, 26'h3FFFFFF, 1'b1, 32'h8C22BEEF};
      vecs[6] = '{2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0BFFFFFF};
      vecs[7] = '{2'd1, 6'h05, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0,       1'b0, 32'h14000000};

      // Reset values
      rst = 1'b1;
      #12 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst_imem_addr", {27'd0, imem_addr}, 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_wr_count", {26'd0, wr_count}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);

      // Single R word with in_last
      do_start();
      send(vecs[0]);
      idle(3);
      drained("t1_drain");
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_wr_count", {26'd0, wr_count}, 32'd1);

      // I then J back-to-back
      do_start();
      for (int i = 1; i <= 2; i++) send(vecs[i]);
      idle(3);
      drained("t2_drain");
      chk("t2_b2b_gap", last_wr_cyc - prev_wr_cyc, 1);
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_wr_count", {26'd0, wr_count}, 32'd2);

      // Overflow: 6 beats held valid, only DEPTH accepted
      do_start();
      send(vecs[6]); send(vecs[7]); send(vecs[3]); send(vecs[1]);
      #1 chk("t3_in_ready_after_full", {31'd0, in_ready}, 32'd0);
      send(vecs[6]); send(vecs[7]);
      idle(3);
      drained("t3_drain");
      chk("t3_done", {31'd0, done}, 32'd1);
      chk("t3_wr_count", {26'd0, wr_count}, 32'd4);

      // Illegal beat between two legal ones, ignored fields
      do_start();
      for (int i = 3; i <= 5; i++) send(vecs[i]);
      idle(3);
      drained("t4_drain");
      chk("t4_err", {31'd0, err}, 32'd1);
      chk("t4_wr_count", {26'd0, wr_count}, 32'd2);
      // abort leaves err but clears done
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("t4_abort_err", {31'd0, err}, 32'd1);
      chk("t4_abort_done", {31'd0, done}, 32'd0);

      // Abort one cycle after an accept
      do_start();
      send(vecs[3]);
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      drained("t5_pending_completed");
      chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t5_done", {31'd0, done}, 32'd0);
      do_start();
      send(vecs[2]);
      idle(3);
      drained("t5_restart_drain");
      chk("t5_restart_count", {26'd0, wr_count}, 32'd1);

      // Reset with a write pending
      do_start();
      send(vecs[6]);
      #1 rst = 1'b1;
      #1;
      q.delete();
      chk("t6_imem_we", {31'd0, imem_we}, 32'd0);
      chk("t6_imem_addr", {27'd0, imem_addr}, 32'd0);
      chk("t6_imem_wdata", imem_wdata, 32'd0);
      chk("t6_wr_count", {26'd0, wr_count}, 32'd0);
      chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t6_done", {31'd0, done}, 32'd0);
      chk("t6_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_idle_in_ready", {31'd0, in_ready}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
